// File: rtl/sb_pkg.sv
// Sideband shared package.
// Holds the sideband packet framing constants used by both the TX serializer
// and the RX deserializer, plus the RX deserializer state encoding.
package sb_pkg;

  // Bits per sideband packet word (one bit per UI).
  localparam int SB_PKT_WIDTH  = 64;
  // Minimum idle UIs required between two packets.
  localparam int SB_MIN_GAP_UI = 32;
  // Width of the shared bit/gap counter; 2^SB_CNT_W exceeds both limits above.
  localparam int SB_CNT_W      = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    GAP  = 2'd2
  } sb_deser_state_e;

endpackage : sb_pkg

// File: rtl/sb_rx_deserializer_if.sv
// Sideband RX deserializer interface.
// Groups the serial input strobe/data, the consumer acknowledge and the
// deserialized word/status outputs.
//   master : deserializer side (drives word, done, busy and error pulses)
//   slave  : stream source / consumer side (drives serial bits and acknowledge)
interface sb_rx_deserializer_if #(
  parameter int PKT_WIDTH = 64
);

  logic                 i_ser_data;
  logic                 i_ser_valid;
  logic                 i_de_ser_done_sampled;
  logic [PKT_WIDTH-1:0] o_deser_data;
  logic                 o_de_ser_done;
  logic                 o_busy;
  logic                 o_overrun;
  logic                 o_frame_error;
  logic                 o_gap_error;

  modport master (
    input  i_ser_data,
    input  i_ser_valid,
    input  i_de_ser_done_sampled,
    output o_deser_data,
    output o_de_ser_done,
    output o_busy,
    output o_overrun,
    output o_frame_error,
    output o_gap_error
  );

  modport slave (
    output i_ser_data,
    output i_ser_valid,
    output i_de_ser_done_sampled,
    input  o_deser_data,
    input  o_de_ser_done,
    input  o_busy,
    input  o_overrun,
    input  o_frame_error,
    input  o_gap_error
  );

endinterface : sb_rx_deserializer_if

// File: rtl/sb_rx_deserializer.sv
// Sideband receive deserializer.
// Assembles the LSB-first serial sideband stream into PKT_WIDTH-bit words,
// presents each word with a done/acknowledge handshake, and enforces the
// PKT_WIDTH-UI packet / MIN_GAP-UI minimum idle framing.
// Ports:
//   i_clk    : sideband sampling clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_enable : block enable; low synchronously clears state, counters,
//              shift register and done (the last word is held)
//   sb       : master side of sb_rx_deserializer_if (serial in, word out,
//              done/ack handshake, busy, overrun/frame/gap error pulses)
module sb_rx_deserializer
  import sb_pkg::*;
#(
  parameter int PKT_WIDTH = SB_PKT_WIDTH,
  parameter int MIN_GAP   = SB_MIN_GAP_UI,
  parameter int CNT_W     = SB_CNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  sb_rx_deserializer_if.master sb
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(PKT_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(MIN_GAP);

  sb_deser_state_e      state_r, state_s;
  // One counter serves as bit counter in RECV and idle counter in GAP.
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [PKT_WIDTH-1:0] shreg_r, shreg_s;
  logic [PKT_WIDTH-1:0] shifted_s;
  logic [PKT_WIDTH-1:0] data_r, data_s;
  logic                 done_r, done_s;
  logic                 busy_r;
  logic                 overrun_r, overrun_s;
  logic                 frame_r, frame_s;
  logic                 gap_err_r, gap_err_s;

  // Next-state, counter, shift register and output computation.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    shreg_s   = shreg_r;
    data_s    = data_r;
    // An acknowledge only matters while a word is pending.
    done_s    = done_r & ~sb.i_de_ser_done_sampled;
    overrun_s = 1'b0;
    frame_s   = 1'b0;
    gap_err_s = 1'b0;
    shifted_s = {sb.i_ser_data, shreg_r[PKT_WIDTH-1:1]};

    if (!i_enable) begin
      state_s = IDLE;
      cnt_s   = CNT_ZERO;
      shreg_s = '0;
      done_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (sb.i_ser_valid) begin
            shreg_s = shifted_s;
            cnt_s   = CNT_ONE;
            state_s = RECV;
          end else begin
            state_s = IDLE;
          end
        end

        RECV: begin
          if (sb.i_ser_valid) begin
            if (cnt_r == LAST_BIT) begin
              // Completion wins over a same-edge acknowledge; only an
              // unacknowledged pending word counts as overrun.
              data_s    = shifted_s;
              done_s    = 1'b1;
              overrun_s = done_r & ~sb.i_de_ser_done_sampled;
              shreg_s   = shifted_s;
              cnt_s     = CNT_ZERO;
              state_s   = GAP;
            end else begin
              shreg_s = shifted_s;
              cnt_s   = cnt_r + CNT_ONE;
            end
          end else begin
            // Partial packet: drop it; this idle cycle is the first gap UI.
            frame_s = 1'b1;
            shreg_s = '0;
            cnt_s   = CNT_ONE;
            state_s = GAP;
          end
        end

        GAP: begin
          if (sb.i_ser_valid) begin
            // Early start still counts as bit 0 of a new packet.
            if (cnt_r < GAP_LIMIT) begin
              gap_err_s = 1'b1;
            end else begin
              gap_err_s = 1'b0;
            end
            shreg_s = shifted_s;
            cnt_s   = CNT_ONE;
            state_s = RECV;
          end else if ((cnt_r + CNT_ONE) == GAP_LIMIT) begin
            cnt_s   = CNT_ZERO;
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          shreg_s = '0;
        end
      endcase
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      shreg_r   <= '0;
      data_r    <= '0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
      frame_r   <= 1'b0;
      gap_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      shreg_r   <= shreg_s;
      data_r    <= data_s;
      done_r    <= done_s;
      busy_r    <= (state_s == RECV);
      overrun_r <= overrun_s;
      frame_r   <= frame_s;
      gap_err_r <= gap_err_s;
    end
  end

  assign sb.o_deser_data  = data_r;
  assign sb.o_de_ser_done = done_r;
  assign sb.o_busy        = busy_r;
  assign sb.o_overrun     = overrun_r;
  assign sb.o_frame_error = frame_r;
  assign sb.o_gap_error   = gap_err_r;

endmodule : sb_rx_deserializer

// File: tb/tb_sb_rx_deserializer.sv
// Self-checking bench for sb_rx_deserializer: directed packet sequences with a
// word scoreboard and registered-pulse counters.
module tb_sb_rx_deserializer;

  logic clk;
  logic rst;
  logic en;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  int ovr_cnt = 0;
  int fe_cnt  = 0;
  int ge_cnt  = 0;

  logic [63:0] exp_q[$];

  sb_rx_deserializer_if #(.PKT_WIDTH(64)) bus ();

  sb_rx_deserializer dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_enable (en),
    .sb       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count each registered error pulse once, just after the edge that sets it.
  always @(posedge clk) begin
    #1;
    if (bus.o_overrun)     ovr_cnt++;
    if (bus.o_frame_error) fe_cnt++;
    if (bus.o_gap_error)   ge_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, return at the following negedge (outputs settled).
  task automatic cycle(input logic v, input logic d, input logic a);
    bus.i_ser_valid           = v;
    bus.i_ser_data            = d;
    bus.i_de_ser_done_sampled = a;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, w[i], 1'b0);
  endtask

  // Full packet, pushes its word; checks busy and gap error after bit 0.
  task automatic send_packet(input logic [63:0] w, input logic exp_gap);
    exp_q.push_back(w);
    cycle(1'b1, w[0], 1'b0);
    check("busy_bit0", {63'd0, bus.o_busy}, 64'd1);
    check("gap_err_bit0", {63'd0, bus.o_gap_error}, {63'd0, exp_gap});
    for (int i = 1; i < 64; i++) cycle(1'b1, w[i], 1'b0);
  endtask

  task automatic check_word(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_done"}, {63'd0, bus.o_de_ser_done}, 64'd1);
      check({tag, "_data"}, bus.o_deser_data, e);
    end
  endtask

  // Ack one cycle (an idle cycle) and confirm done drops.
  task automatic ack(input string tag);
    cycle(1'b0, 1'b0, 1'b1);
    check({tag, "_ack_done"}, {63'd0, bus.o_de_ser_done}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    bus.i_ser_valid           = 1'b0;
    bus.i_ser_data            = 1'b0;
    bus.i_de_ser_done_sampled = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_data", bus.o_deser_data, 64'd0);
    check("rst_done", {63'd0, bus.o_de_ser_done}, 64'd0);
    check("rst_busy", {63'd0, bus.o_busy}, 64'd0);
    check("rst_errs", {61'd0, bus.o_overrun, bus.o_frame_error, bus.o_gap_error}, 64'd0);
    rst = 1'b0;
    idle(2);

    // Single packet, then ack.
    send_packet(64'hDEAD_BEEF_A5A5_0F0F, 1'b0);
    check_word("p1");
    check("p1_busy_after", {63'd0, bus.o_busy}, 64'd0);
    ack("p1");
    idle(31);
    check("p1_no_errs", 64'(ovr_cnt + fe_cnt + ge_cnt), 64'd0);

    // Two packets separated by exactly the minimum gap, acked.
    send_packet(64'h1, 1'b0);
    check_word("p2a");
    ack("p2a");
    idle(31);
    send_packet(64'hFFFF_0000_FFFF_0000, 1'b0);
    check_word("p2b");
    ack("p2b");
    idle(31);
    check("p2_gap_errs", 64'(ge_cnt), 64'd0);
    check("p2_frame_errs", 64'(fe_cnt), 64'd0);

    // Same two packets without acking the first -> overrun.
    send_packet(64'h1, 1'b0);
    check_word("p3a");
    idle(32);
    check("p3_done_held", {63'd0, bus.o_de_ser_done}, 64'd1);
    send_packet(64'hFFFF_0000_FFFF_0000, 1'b0);
    check("p3_overrun", {63'd0, bus.o_overrun}, 64'd1);
    check_word("p3b");
    idle(1);
    check("p3_overrun_pulse", {63'd0, bus.o_overrun}, 64'd0);
    check("p3_done_stays", {63'd0, bus.o_de_ser_done}, 64'd1);
    ack("p3");
    idle(30);
    check("p3_ovr_cnt", 64'(ovr_cnt), 64'd1);

    // Valid drops after 20 bits -> frame error, no done; then a clean packet.
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 20);
    cycle(1'b0, 1'b0, 1'b0);
    check("p4_frame_err", {63'd0, bus.o_frame_error}, 64'd1);
    check("p4_no_done", {63'd0, bus.o_de_ser_done}, 64'd0);
    check("p4_busy", {63'd0, bus.o_busy}, 64'd0);
    idle(31);
    send_packet(64'h0123_4567_89AB_CDEF, 1'b0);
    check_word("p4");
    ack("p4");
    idle(31);
    check("p4_fe_cnt", 64'(fe_cnt), 64'd1);

    // Short gap (10 idle) -> gap error on first bit, word still delivered.
    send_packet(64'hCAFE_F00D_1234_5678, 1'b0);
    check_word("p5a");
    ack("p5a");
    idle(9);
    send_packet(64'h55AA_55AA_55AA_55AA, 1'b1);
    check_word("p5b");
    ack("p5b");
    idle(31);
    check("p5_ge_cnt", 64'(ge_cnt), 64'd1);

    // Async reset at bit 30, then a clean packet.
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 30);
    check("p6_busy_pre", {63'd0, bus.o_busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("p6_rst_data", bus.o_deser_data, 64'd0);
    check("p6_rst_busy", {63'd0, bus.o_busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send_packet(64'hA1B2_C3D4_E5F6_0718, 1'b0);
    check_word("p6");
    idle(32);

    // Leave the word pending, start a packet, drop enable at bit 30.
    send_bits(64'h0F0F_0F0F_0F0F_0F0F, 30);
    en = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    check("p7_done_clr", {63'd0, bus.o_de_ser_done}, 64'd0);
    check("p7_busy_clr", {63'd0, bus.o_busy}, 64'd0);
    check("p7_data_held", bus.o_deser_data, 64'hA1B2_C3D4_E5F6_0718);
    cycle(1'b1, 1'b1, 1'b0);
    check("p7_ignored", {63'd0, bus.o_busy}, 64'd0);
    en = 1'b1;
    idle(1);
    send_packet(64'h7766_5544_3322_1100, 1'b0);
    check_word("p7");
    ack("p7");
    check("final_fe", 64'(fe_cnt), 64'd1);
    check("final_ge", 64'(ge_cnt), 64'd1);
    check("final_ovr", 64'(ovr_cnt), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule : tb_sb_rx_deserializer
